hack_memory_bus: RTL and testbench
==================================

HACK_MEMORY_BUS -- requirements
Module: hack_memory_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 2048, the number of data RAM words at 0x0000..RAM_WORDS-1 (power of two, at most 4096).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, the number of clk cycles per UART bit (at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port addressM, input, 16 bits (bit 15 ignored): CPU data address.
REQ-006 SHALL have port outM, input, 16 bits: CPU write data.
REQ-007 SHALL have port writeM, input, 1 bit: CPU write strobe, sampled every cycle.
REQ-008 SHALL have port inM, output, 16 bits: read data returned to the CPU.
REQ-009 SHALL have port buttons, input, 4 bits: board push-buttons, asynchronous.
REQ-010 SHALL have port leds, output, 8 bits: LED register.
REQ-011 SHALL have port tx, output, 1 bit: UART serial output, idle high.

Function
REQ-012 SHALL decode addressM[14:0] as follows.
- 0x0000..RAM_WORDS-1: RAM.
- 0x1000: LED register (read/write, low 8 bits).
- 0x1001: UART TX data (write; reads return 0).
- 0x1002: UART status (read-only; bit0 = busy, bit1 = overrun, other bits 0).
- 0x1003: buttons (read-only; bits 3:0).
- Any other address: reads return 0x0000; writes are ignored.
REQ-013 SHALL register every read: inM on cycle n+1 equals the decoded read value for addressM on cycle n (one-cycle latency).
REQ-014 SHALL perform a write on the rising edge where writeM=1, storing outM to the decoded target; writes to read-only addresses have no effect.
REQ-015 SHALL be write-first on a read-write collision: with writeM=1 to address X on cycle n, inM on n+1 equals the value just written (low 8 bits zero-extended for the LED register).
REQ-016 SHALL pass buttons through a two-flop synchronizer before it is readable, giving a three-cycle input-to-inM latency.
REQ-017 SHALL implement the UART TX state machine IDLE -> START -> DATA -> STOP -> IDLE, 8N1, LSB first, with each state bit lasting exactly CLKS_PER_BIT cycles.
REQ-018 SHALL accept a write to 0x1001 only in IDLE: latch outM[7:0], enter START on the next edge, and drive tx low from that edge.
REQ-019 SHALL ignore a write to 0x1001 outside IDLE (data dropped, transmission unaffected) and set overrun=1.
REQ-020 SHALL report busy=1 in START, DATA and STOP, and clear busy on the edge that returns the state machine to IDLE.
- A write in the final STOP cycle is therefore refused and sets overrun.
- A write in the first IDLE cycle is accepted.
REQ-021 SHALL clear overrun on the edge following a status read (addressM=0x1002, writeM=0); if an overrun sets on that same edge, set takes priority.
REQ-022 SHALL hold tx high in IDLE and STOP, and drive data bit k during DATA bit slot k.
REQ-023 SHALL use a bit-timer counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index, both wrapping to 0 at slot end with no off-by-one.

Reset
REQ-024 SHALL, on a rising edge with reset=1, set the following and abort any transmission in progress:
- inM to 0x0000
- leds to 0x00
- tx to 1
- UART state to IDLE, with busy=0 and overrun=0
- bit timer and bit index to 0
REQ-025 SHALL leave RAM contents unchanged by reset, and SHALL ignore writeM while reset=1.

Verification
REQ-026 SHALL verify RAM write/read: write 0x3039 to 0x0005, then read 0x0005 -> inM=0x3039 one cycle after the address is presented; read 0x0FFF -> 0x0000.
REQ-027 SHALL verify the collision case: writeM=1 with outM=0xABCD to 0x0010 -> inM=0xABCD on the next cycle; LED write of 0x1234 -> leds=0x34 and readback=0x0034.
REQ-028 SHALL verify a UART frame with CLKS_PER_BIT=4: write 0x0055 to 0x1001 -> tx reads 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy=1 for exactly 40 cycles.
REQ-029 SHALL verify overrun: a second write to 0x1001 while busy -> the frame is unchanged and status=0x0003; a status read followed by a further read after busy clears -> 0x0000.
REQ-030 SHALL verify reset mid-frame: assert reset in DATA slot 3 -> tx=1, status=0x0000 and leds=0x00 on the next edge; RAM 0x0005 still reads 0x3039.
REQ-031 SHALL verify buttons: drive buttons=0xA -> a read of 0x1003 returns 0x000A no earlier than 3 cycles after the change; reads of 0x1001 and 0x7FFF return 0x0000.

Source files
------------

// File: rtl/hack_memory_bus.sv
// Hack CPU data-memory bus: RAM, LED register, 8N1 UART transmitter and a
// synchronized button port, all returning read data one cycle after the address.
module hack_memory_bus #(
  parameter int RAM_WORDS    = 2048,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [3:0]  buttons,
  output logic [7:0]  leds,
  output logic        tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   RAM_TOP  = 16'(RAM_WORDS);
  localparam logic [14:0]   A_LED    = 15'h1000;
  localparam logic [14:0]   A_TX     = 15'h1001;
  localparam logic [14:0]   A_STATUS = 15'h1002;
  localparam logic [14:0]   A_BTN    = 15'h1003;

  // Handshake: the CPU bus has no ready; every cycle is a transfer, writeM
  // qualifies a write and the read result always appears on inM one cycle later.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  uart_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    leds_q, leds_d;
  logic [15:0]   inm_q, inm_d;
  logic [3:0]    btn_s1_q, btn_s1_d;
  logic [3:0]    btn_s2_q, btn_s2_d;

  logic [15:0]   mem [RAM_WORDS];
  logic [14:0]   addr;
  logic          is_ram;
  logic          we;
  logic          busy;
  logic          uart_wr;
  logic          slot_end;
  logic [15:0]   rd;
  logic          unused_addr_bit;

  assign addr            = addressM[14:0];
  assign unused_addr_bit = addressM[15];
  assign is_ram          = {1'b0, addr} < RAM_TOP;
  assign we              = writeM & ~reset;
  assign busy            = (state_q != S_IDLE);
  assign uart_wr         = we && (addr == A_TX);
  assign slot_end        = (timer_q == BIT_LAST);

  // Read mux is write-first: a write in the same cycle returns the new value.
  always_comb begin
    rd = 16'h0000;
    if (is_ram) begin
      rd = we ? outM : mem[addr[AW-1:0]];
    end else begin
      case (addr)
        A_LED:    rd = we ? {8'h00, outM[7:0]} : {8'h00, leds_q};
        A_STATUS: rd = {14'b0, overrun_q, busy};
        A_BTN:    rd = {12'b0, btn_s2_q};
        default:  rd = 16'h0000;
      endcase
    end
  end

  always_comb begin
    inm_d    = rd;
    leds_d   = (we && addr == A_LED) ? outM[7:0] : leds_q;
    btn_s1_d = buttons;
    btn_s2_d = btn_s1_q;
    // A refused TX write sets overrun even when a status read would clear it.
    overrun_d = overrun_q;
    if (uart_wr && busy) begin
      overrun_d = 1'b1;
    end else if (addr == A_STATUS && !writeM) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (uart_wr) begin
          data_d  = outM[7:0];
          state_d = S_START;
          timer_d = '0;
          idx_d   = 3'd0;
        end
      end
      S_START: begin
        if (slot_end) begin
          timer_d = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (slot_end) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (slot_end) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // tx is registered from the next state so it changes on the same edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      idx_q     <= 3'd0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
      leds_q    <= 8'h00;
      inm_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
      leds_q    <= leds_d;
      inm_q     <= inm_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q   <= data_d;
    btn_s1_q <= btn_s1_d;
    btn_s2_q <= btn_s2_d;
  end

  always_ff @(posedge clk) begin
    if (we && is_ram) mem[addr[AW-1:0]] <= outM;
  end

  assign inM  = inm_q;
  assign leds = leds_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_hack_memory_bus.sv
// Bench for hack_memory_bus: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a cycle-count based model.
module tb_hack_memory_bus;

  localparam int CPB   = 4;
  localparam int WORDS = 2048;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addressM = 16'h0000;
  logic [15:0] outM = 16'h0000;
  logic        writeM = 1'b0;
  logic [3:0]  buttons = 4'h0;
  logic [15:0] inM;
  logic [7:0]  leds;
  logic        tx;

  always #5 clk = ~clk;

  hack_memory_bus #(.RAM_WORDS(WORDS), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM),
    .writeM(writeM), .inM(inM), .buttons(buttons), .leds(leds), .tx(tx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame timing derived from the cycle at which the
  // transmission was accepted, RAM as a plain array with a written mask.
  int          cyc = 0;
  logic [15:0] m_mem [WORDS];
  bit          m_known [WORDS];
  logic [7:0]  m_leds = 8'h00;
  bit          m_ov = 1'b0;
  bit          f_act = 1'b0;
  int          f_start = 0;
  logic [7:0]  f_data = 8'h00;
  logic [3:0]  bh0 = 4'h0, bh1 = 4'h0;
  logic [15:0] e_inm = 16'h0000;
  bit          e_inm_known = 1'b0;
  logic        e_tx = 1'b1;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    logic [14:0] a;
    logic [15:0] rv;
    bit          rk;
    bit          busy_pre;
    bit          ov_set;
    int          ai;
    int          off;
    int          sl;
    cyc++;
    a  = addressM[14:0];
    ai = int'(a);
    busy_pre = f_act && ((cyc - f_start) <= FRAME);
    if (reset) begin
      e_inm = 16'h0000; e_inm_known = 1'b1;
      m_leds = 8'h00; m_ov = 1'b0; f_act = 1'b0; model_on = 1'b1;
    end else begin
      rv = 16'h0000; rk = 1'b1; ov_set = 1'b0;
      if (ai < WORDS) begin
        if (writeM) rv = outM;
        else begin rv = m_mem[ai]; rk = m_known[ai]; end
      end else if (a == 15'h1000) rv = writeM ? {8'h00, outM[7:0]} : {8'h00, m_leds};
      else if (a == 15'h1002) rv = {14'b0, m_ov, busy_pre};
      else if (a == 15'h1003) rv = {12'b0, bh1};
      if (writeM) begin
        if (ai < WORDS) begin m_mem[ai] = outM; m_known[ai] = 1'b1; end
        else if (a == 15'h1000) m_leds = outM[7:0];
        else if (a == 15'h1001) begin
          if (busy_pre) ov_set = 1'b1;
          else begin f_act = 1'b1; f_start = cyc; f_data = outM[7:0]; end
        end
      end
      if (ov_set) m_ov = 1'b1;
      else if (a == 15'h1002 && !writeM) m_ov = 1'b0;
      e_inm = rv; e_inm_known = rk;
    end
    bh1 = bh0; bh0 = buttons;
    off = cyc - f_start;
    e_tx = 1'b1;
    if (f_act && off < FRAME) begin
      sl = off / CPB;
      if (sl == 0) e_tx = 1'b0;
      else if (sl <= 8) e_tx = f_data[sl-1];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      if (e_inm_known) check16("model_inM", inM, e_inm);
      check16("model_leds", {8'h00, leds}, {8'h00, m_leds});
      check16("model_tx", {15'b0, tx}, {15'b0, e_tx});
    end
  end

  // Called aligned to a negedge; returns at the next negedge.
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
    addressM = a; outM = d; writeM = w;
    @(negedge clk);
  endtask

  logic [0:43] tx_pat;

  // Watches a frame from its first cycle; ovr adds a refused write and a status read.
  task automatic frame_watch(input bit ovr);
    int busy_cnt;
    busy_cnt = 0;
    for (int i = 0; i < 46; i++) begin
      if (i < 44) check16("frame_tx", {15'b0, tx}, {15'b0, tx_pat[i]});
      if (!ovr && i >= 1 && inM[0]) busy_cnt++;
      if (ovr && i == 2) check16("overrun_status", inM, 16'h0003);
      if (ovr && i == 0) drive(16'h1001, 16'h00FF, 1'b1);
      else if (ovr && i > 1) drive(16'h0FFF, 16'h0000, 1'b0);
      else drive(16'h1002, 16'h0000, 1'b0);
    end
    if (!ovr) check16("busy_cycles", 16'(busy_cnt), 16'd40);
  endtask

  initial begin
    tx_pat = {4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(16'h0005, 16'hDEAD, 1'b1);
    check16("reset_inM", inM, 16'h0000);
    check16("reset_leds", {8'h00, leds}, 16'h0000);
    check16("reset_tx", {15'b0, tx}, 16'h0001);
    reset = 1'b0;

    drive(16'h0005, 16'h3039, 1'b1);
    drive(16'h0005, 16'h0000, 1'b0);
    check16("ram_read", inM, 16'h3039);
    drive(16'h0FFF, 16'h0000, 1'b0);
    check16("unmapped_0fff", inM, 16'h0000);
    drive(16'h8005, 16'h0000, 1'b0);
    check16("bit15_alias", inM, 16'h3039);

    drive(16'h0010, 16'hABCD, 1'b1);
    check16("collision", inM, 16'hABCD);
    drive(16'h1000, 16'h1234, 1'b1);
    check16("led_collision", inM, 16'h0034);
    check16("led_value", {8'h00, leds}, 16'h0034);
    drive(16'h1000, 16'h0000, 1'b0);
    check16("led_read", inM, 16'h0034);

    drive(16'h1001, 16'h0055, 1'b1);
    frame_watch(1'b0);
    drive(16'h1001, 16'h0055, 1'b1);
    frame_watch(1'b1);
    drive(16'h1002, 16'h0000, 1'b0);
    drive(16'h1002, 16'h0000, 1'b0);
    check16("status_cleared", inM, 16'h0000);

    drive(16'h1001, 16'h0055, 1'b1);
    for (int i = 0; i < 17; i++) drive(16'h0FFF, 16'h0000, 1'b0);
    reset = 1'b1;
    drive(16'h0FFF, 16'h0000, 1'b0);
    check16("midreset_tx", {15'b0, tx}, 16'h0001);
    check16("midreset_leds", {8'h00, leds}, 16'h0000);
    check16("midreset_inM", inM, 16'h0000);
    reset = 1'b0;
    drive(16'h1002, 16'h0000, 1'b0);
    check16("midreset_status", inM, 16'h0000);
    drive(16'h0005, 16'h0000, 1'b0);
    check16("ram_kept", inM, 16'h3039);

    buttons = 4'hA;
    for (int k = 1; k <= 5; k++) begin
      drive(16'h1003, 16'h0000, 1'b0);
      check16("buttons", inM, (k >= 3) ? 16'h000A : 16'h0000);
    end
    drive(16'h1001, 16'h0000, 1'b0);
    check16("tx_reg_read", inM, 16'h0000);
    drive(16'h7FFF, 16'h0000, 1'b0);
    check16("unmapped_7fff", inM, 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 7))
        0, 1:    a = 16'($urandom_range(0, 15));
        2:       a = 16'($urandom_range(0, WORDS - 1));
        3:       a = 16'h1000;
        4:       a = 16'h1001;
        5:       a = 16'h1002;
        6:       a = 16'h1003;
        default: a = 16'($urandom_range(0, 32767));
      endcase
      a[15] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) buttons = 4'($urandom_range(0, 15));
      drive(a, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    drive(16'h0FFF, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
